// File: rtl/pc_alu_datapath_pkg.sv
// Shared definitions for the PC/ALU datapath: default width and ALU opcodes.
package pc_alu_datapath_pkg;

  localparam int WIDTH_DEF = 8;

  typedef enum logic [1:0] {
    ALU_ADD = 2'b00,
    ALU_SUB = 2'b01,
    ALU_AND = 2'b10,
    ALU_OR  = 2'b11
  } alu_op_e;

endpackage

// File: rtl/pc_alu_unit.sv
// Combinational 2-bit-controlled ALU with a zero flag on the truncated result.
module pc_alu_unit
  import pc_alu_datapath_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic [1:0]       c_alu,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] d_alu,
  output logic             zero
);

  always_comb begin
    d_alu = '0;
    case (alu_op_e'(c_alu))
      ALU_ADD: d_alu = a + b;
      ALU_SUB: d_alu = a - b;
      ALU_AND: d_alu = a & b;
      ALU_OR:  d_alu = a | b;
      default: d_alu = '0;
    endcase
  end

  assign zero = (d_alu == '0);

endmodule

// File: rtl/pc_alu_datapath.sv
// Sequencing core: program counter, PC-relative jump adder and ALU whose
// zero flag gates conditional branches.
module pc_alu_datapath
  import pc_alu_datapath_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       c_alu,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] d_alu,
  output logic             zero,
  input  logic [WIDTH-1:0] j_offset,
  input  logic             branch_en,
  input  logic             ret_en,
  input  logic [WIDTH-1:0] ret_addr,
  output logic [WIDTH-1:0] pc_jump,
  output logic [WIDTH-1:0] pc_count
);

  logic             load;
  logic [WIDTH-1:0] load_val;

  pc_alu_unit #(.WIDTH(WIDTH)) u_alu (
    .c_alu (c_alu),
    .a     (a),
    .b     (b),
    .d_alu (d_alu),
    .zero  (zero)
  );

  // Offset is relative to the current PC, not PC+1.
  assign pc_jump  = pc_count + j_offset;

  // A stack return wins over a taken branch.
  assign load     = ret_en | (branch_en & zero);
  assign load_val = ret_en ? ret_addr : pc_jump;

  always_ff @(posedge clk) begin
    if (reset)     pc_count <= '0;
    else if (load) pc_count <= load_val;
    else           pc_count <= pc_count + WIDTH'(1);
  end

endmodule

// File: tb/tb_pc_alu_datapath.sv
// Self-checking bench: directed test-plan items plus randomized cycles
// against an arithmetic reference model of the PC and ALU.
module tb_pc_alu_datapath;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] c_alu;
  logic [7:0] a, b, j_offset, ret_addr;
  logic       branch_en, ret_en;
  logic [7:0] d_alu, pc_jump, pc_count;
  logic       zero;

  int checks = 0;
  int errors = 0;
  int m_pc   = 0;

  pc_alu_datapath #(.WIDTH(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .c_alu     (c_alu),
    .a         (a),
    .b         (b),
    .d_alu     (d_alu),
    .zero      (zero),
    .j_offset  (j_offset),
    .branch_en (branch_en),
    .ret_en    (ret_en),
    .ret_addr  (ret_addr),
    .pc_jump   (pc_jump),
    .pc_count  (pc_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int ref_alu(input int op, input int x, input int y);
    case (op)
      0:       return (x + y) % 256;
      1:       return (x - y + 256) % 256;
      2:       return x & y;
      default: return x | y;
    endcase
  endfunction

  task automatic drive(input logic rst, input logic [1:0] op, input logic [7:0] aa,
                       input logic [7:0] bb, input logic [7:0] jo, input logic be,
                       input logic re, input logic [7:0] ra);
    reset = rst; c_alu = op; a = aa; b = bb; j_offset = jo;
    branch_en = be; ret_en = re; ret_addr = ra;
  endtask

  // Check the combinational outputs, clock one edge, then check the new PC.
  task automatic tick(input string tag);
    int r, nxt;
    #1;
    r = ref_alu(int'(c_alu), int'(a), int'(b));
    chk({tag, ".d_alu"}, d_alu, r);
    chk({tag, ".zero"}, zero, (r == 0));
    chk({tag, ".pc_jump"}, pc_jump, (m_pc + int'(j_offset)) % 256);
    if (reset)                   nxt = 0;
    else if (ret_en)             nxt = ret_addr;
    else if (branch_en && r == 0) nxt = (m_pc + int'(j_offset)) % 256;
    else                         nxt = (m_pc + 1) % 256;
    @(posedge clk);
    #1;
    m_pc = nxt;
    chk({tag, ".pc_count"}, pc_count, m_pc);
  endtask

  task automatic load_pc(input logic [7:0] v);
    drive(0, 2'b00, 8'h01, 8'h00, 8'h00, 0, 1, v);
    tick("load");
  endtask

  initial begin
    // Reset state
    drive(1, 2'b00, 8'h00, 8'h00, 8'h2A, 0, 0, 8'h00);
    repeat (2) @(posedge clk);
    #1;
    m_pc = 0;
    chk("reset.pc_count", pc_count, 8'h00);
    chk("reset.pc_jump", pc_jump, 8'h2A);

    // Free run
    drive(0, 2'b00, 8'h01, 8'h02, 8'h00, 0, 0, 8'h00);
    tick("run1"); chk("run1.abs", pc_count, 8'h01);
    tick("run2"); chk("run2.abs", pc_count, 8'h02);
    tick("run3"); chk("run3.abs", pc_count, 8'h03);

    // Increment wrap
    load_pc(8'hFF);
    drive(0, 2'b00, 8'h01, 8'h02, 8'h00, 0, 0, 8'h00);
    tick("wrap"); chk("wrap.abs", pc_count, 8'h00);

    // ALU sweep
    drive(0, 2'b00, 8'h0C, 8'h05, 8'h00, 0, 0, 8'h00); #1;
    chk("add", d_alu, 8'h11); chk("add.z", zero, 1'b0);
    c_alu = 2'b01; #1; chk("sub", d_alu, 8'h07); chk("sub.z", zero, 1'b0);
    c_alu = 2'b10; #1; chk("and", d_alu, 8'h04); chk("and.z", zero, 1'b0);
    c_alu = 2'b11; #1; chk("or", d_alu, 8'h0D); chk("or.z", zero, 1'b0);
    c_alu = 2'b01; a = 8'h33; b = 8'h33; #1;
    chk("sub0", d_alu, 8'h00); chk("sub0.z", zero, 1'b1);
    c_alu = 2'b00; a = 8'hFF; b = 8'h01; #1;
    chk("addwrap", d_alu, 8'h00); chk("addwrap.z", zero, 1'b1);

    // Taken branch, backwards offset
    load_pc(8'h05);
    drive(0, 2'b01, 8'h10, 8'h10, 8'hFE, 1, 0, 8'h00); #1;
    chk("br.pc_jump", pc_jump, 8'h03);
    tick("br_taken"); chk("br_taken.abs", pc_count, 8'h03);

    // Not taken
    load_pc(8'h05);
    drive(0, 2'b01, 8'h10, 8'h11, 8'hFE, 1, 0, 8'h00);
    tick("br_not"); chk("br_not.abs", pc_count, 8'h06);

    // Jump target wrapping forwards
    load_pc(8'hF0);
    drive(0, 2'b01, 8'h10, 8'h10, 8'h20, 1, 0, 8'h00);
    tick("br_fwrap"); chk("br_fwrap.abs", pc_count, 8'h10);

    // Return priority
    drive(0, 2'b01, 8'h10, 8'h10, 8'hFE, 1, 1, 8'h40);
    tick("ret_br"); chk("ret_br.abs", pc_count, 8'h40);
    drive(0, 2'b01, 8'h10, 8'h11, 8'hFE, 1, 1, 8'h40);
    tick("ret_nz"); chk("ret_nz.abs", pc_count, 8'h40);

    // Reset mid-operation beats a taken branch and a return
    drive(1, 2'b01, 8'h10, 8'h10, 8'hFE, 1, 0, 8'h00);
    tick("rst_br"); chk("rst_br.abs", pc_count, 8'h00);
    load_pc(8'h22);
    drive(1, 2'b00, 8'h00, 8'h00, 8'h00, 0, 1, 8'h40);
    tick("rst_ret"); chk("rst_ret.abs", pc_count, 8'h00);

    // Reset pulse between edges has no effect
    load_pc(8'h22);
    reset = 1'b1; #2;
    chk("rst_async", pc_count, 8'h22);
    drive(0, 2'b00, 8'h01, 8'h01, 8'h00, 0, 0, 8'h00);
    tick("after_pulse"); chk("after_pulse.abs", pc_count, 8'h23);

    // Randomized cycles
    for (int i = 0; i < 400; i++) begin
      logic [7:0] ra, rb;
      ra = 8'($urandom);
      rb = ($urandom_range(0, 2) == 0) ? ra : 8'($urandom);
      drive(($urandom_range(0, 31) == 0), 2'($urandom), ra, rb, 8'($urandom),
            1'($urandom), ($urandom_range(0, 7) == 0), 8'($urandom));
      tick("rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
